// File: rtl/pos_window_counter.sv
// Cascadable position counter with a start/end window FSM and an LS85-style
// registered magnitude compare of count against win_start.
//
// state  | meaning
// IDLE   | outside the window, waiting for count == win_start on an increment
// ACTIVE | inside the window, waiting for count == win_end on an increment
module pos_window_counter #(
  parameter int WIDTH   = 8,
  parameter int WRAP_AT = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enp,
  input  logic             ent,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             wr_start,
  input  logic             wr_end,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             win_active,
  output logic             win_start_p,
  output logic             win_end_p,
  output logic             cmp_gt,
  output logic             cmp_eq,
  output logic             cmp_lt
);

  localparam int NIBBLES = WIDTH / 4;
  localparam logic [WIDTH-1:0] WRAP_VAL = WIDTH'(WRAP_AT);

  typedef enum logic {IDLE, ACTIVE} winStateT;

  winStateT        winState;
  logic [WIDTH-1:0] winStart;
  logic [WIDTH-1:0] winEnd;
  logic             inc;
  logic             atWrap;
  logic             hitStart;
  logic             hitEnd;
  logic             gtNext;
  logic             eqNext;
  logic             ltNext;

  assign atWrap   = (count == WRAP_VAL);
  assign inc      = enp && ent && !load;
  assign hitStart = (count == winStart);
  assign hitEnd   = (count == winEnd);
  assign tc       = ent && atWrap;
  assign win_active = (winState == ACTIVE);

  // Nibble-sliced compare, LSB first: a higher nibble that differs overrides
  // whatever the lower nibbles decided, exactly like chained LS85 parts.
  always_comb begin
    gtNext = 1'b0;
    eqNext = 1'b1;
    ltNext = 1'b0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (count[4*n +: 4] > winStart[4*n +: 4]) begin
        gtNext = 1'b1;
        eqNext = 1'b0;
        ltNext = 1'b0;
      end else if (count[4*n +: 4] < winStart[4*n +: 4]) begin
        gtNext = 1'b0;
        eqNext = 1'b0;
        ltNext = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= atWrap ? '0 : count + WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      winStart <= '0;
      winEnd   <= '0;
    end else begin
      if (wr_start) winStart <= wr_data;
      if (wr_end)   winEnd   <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      winState    <= IDLE;
      win_start_p <= 1'b0;
      win_end_p   <= 1'b0;
    end else begin
      win_start_p <= 1'b0;
      win_end_p   <= 1'b0;
      if (load) begin
        winState <= IDLE;
      end else if (inc) begin
        case (winState)
          IDLE: begin
            if (hitStart && hitEnd) begin
              win_start_p <= 1'b1;
              win_end_p   <= 1'b1;
            end else if (hitStart) begin
              winState    <= ACTIVE;
              win_start_p <= 1'b1;
            end
          end
          ACTIVE: begin
            if (hitEnd) begin
              winState  <= IDLE;
              win_end_p <= 1'b1;
            end
          end
          default: winState <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cmp_gt <= 1'b0;
      cmp_eq <= 1'b1;
      cmp_lt <= 1'b0;
    end else begin
      cmp_gt <= gtNext;
      cmp_eq <= eqNext;
      cmp_lt <= ltNext;
    end
  end

endmodule
